// File: rtl/puf_pkg.sv
// Shared types for the ring-oscillator race PUF cell.
package puf_pkg;

    typedef enum logic {
        RACE   = 1'b0,
        WINDOW = 1'b1
    } puf_mode_e;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SETTLE,
        RUN,
        STOP,
        RESP
    } puf_state_e;

    // Select width for an N:1 RO mux; never narrower than one bit.
    function automatic int unsigned clog2_sel(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ro_race_counter.sv
// RO-clocked event counter with a sticky terminal-count flag (RACE) or saturation
// (WINDOW), plus a synchroniser carrying the flag into the system clock domain.
module ro_race_counter
    import puf_pkg::*;
#(
    parameter int unsigned CNT_W      = 22,
    parameter int unsigned TERM_COUNT = 1 << 20,
    parameter int unsigned SYNC_STG   = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ro_clk,
    input  logic             clr,
    input  logic             race,
    output logic [CNT_W-1:0] count,
    output logic             fin_sync
);

    localparam logic [CNT_W-1:0] TERM_M1 = CNT_W'(TERM_COUNT - 1);

    logic                fin;
    logic [SYNC_STG-1:0] sync_q;

    // RACE stops at the terminal count; WINDOW saturates at all-ones.
    always_ff @(posedge ro_clk or posedge clr) begin
        if (clr) begin
            count <= '0;
            fin   <= 1'b0;
        end else if (race) begin
            if (!fin) begin
                count <= count + CNT_W'(1);
                if (count == TERM_M1) begin
                    fin <= 1'b1;
                end
            end
        end else if (count != '1) begin
            count <= count + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STG-2:0], fin};
        end
    end

    assign fin_sync = sync_q[SYNC_STG-1];

endmodule

// File: rtl/puf_race_unit.sv
// One-bit RO race PUF cell. The RO banks are external hard macros: this unit drives
// their one-hot enables, muxes the selected pair and decides the race or window.
module puf_race_unit
    import puf_pkg::*;
#(
    parameter int unsigned N_RO        = 16,
    parameter int unsigned CNT_W       = 22,
    parameter int unsigned TERM_COUNT  = 1 << 20,
    parameter int unsigned SETTLE_CYC  = 16,
    parameter int unsigned WINDOW_CYC  = 4096,
    parameter int unsigned DRAIN_CYC   = 8,
    parameter int unsigned TIMEOUT_CYC = 1 << 20,
    parameter int unsigned SYNC_STG    = 2,
    localparam int unsigned SEL_W      = clog2_sel(N_RO)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [2*SEL_W-1:0] challenge,
    input  logic               mode,
    output logic               busy,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic               resp,
    output logic               tie,
    output logic               timeout,
    output logic [CNT_W-1:0]   count_a,
    output logic [CNT_W-1:0]   count_b,
    input  logic [N_RO-1:0]    ro_a,
    input  logic [N_RO-1:0]    ro_b,
    output logic [N_RO-1:0]    ro_en_a,
    output logic [N_RO-1:0]    ro_en_b
);

    localparam int unsigned CYC_M0  = (TIMEOUT_CYC > WINDOW_CYC) ? TIMEOUT_CYC : WINDOW_CYC;
    localparam int unsigned CYC_M1  = (SETTLE_CYC > CYC_M0) ? SETTLE_CYC : CYC_M0;
    localparam int unsigned CYC_MAX = (DRAIN_CYC > CYC_M1) ? DRAIN_CYC : CYC_M1;
    localparam int unsigned CYC_W   = $clog2(CYC_MAX + 1);

    puf_state_e       state;
    puf_mode_e        mode_q;
    logic [SEL_W-1:0] sel_a;
    logic [SEL_W-1:0] sel_b;
    logic [CYC_W-1:0] cyc;
    logic             cnt_clr;
    logic             ro_clr_c;
    logic             fin_a_s;
    logic             fin_b_s;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;

    assign ro_clr_c = reset | cnt_clr;

    ro_race_counter #(
        .CNT_W      (CNT_W),
        .TERM_COUNT (TERM_COUNT),
        .SYNC_STG   (SYNC_STG)
    ) u_cnt_a (
        .clock    (clock),
        .reset    (reset),
        .ro_clk   (ro_a[sel_a]),
        .clr      (ro_clr_c),
        .race     (mode_q == RACE),
        .count    (cnt_a),
        .fin_sync (fin_a_s)
    );

    ro_race_counter #(
        .CNT_W      (CNT_W),
        .TERM_COUNT (TERM_COUNT),
        .SYNC_STG   (SYNC_STG)
    ) u_cnt_b (
        .clock    (clock),
        .reset    (reset),
        .ro_clk   (ro_b[sel_b]),
        .clr      (ro_clr_c),
        .race     (mode_q == RACE),
        .count    (cnt_b),
        .fin_sync (fin_b_s)
    );

    // Sequencer: one shared cycle counter times SETTLE, RUN and STOP.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            mode_q     <= RACE;
            sel_a      <= '0;
            sel_b      <= '0;
            cyc        <= '0;
            cnt_clr    <= 1'b0;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            resp       <= 1'b0;
            tie        <= 1'b0;
            timeout    <= 1'b0;
            count_a    <= '0;
            count_b    <= '0;
            ro_en_a    <= '0;
            ro_en_b    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sel_a   <= challenge[SEL_W-1:0];
                        sel_b   <= challenge[2*SEL_W-1:SEL_W];
                        mode_q  <= puf_mode_e'(mode);
                        ro_en_a <= N_RO'(1) << challenge[SEL_W-1:0];
                        ro_en_b <= N_RO'(1) << challenge[2*SEL_W-1:SEL_W];
                        cnt_clr <= 1'b1;
                        busy    <= 1'b1;
                        resp    <= 1'b0;
                        tie     <= 1'b0;
                        timeout <= 1'b0;
                        count_a <= '0;
                        count_b <= '0;
                        cyc     <= '0;
                        state   <= CLEAR;
                    end
                end
                CLEAR: begin
                    cyc   <= '0;
                    state <= SETTLE;
                end
                SETTLE: begin
                    if (cyc == CYC_W'(SETTLE_CYC - 1)) begin
                        cyc     <= '0;
                        cnt_clr <= 1'b0;
                        state   <= RUN;
                    end else begin
                        cyc <= cyc + CYC_W'(1);
                    end
                end
                RUN: begin
                    if (mode_q == WINDOW) begin
                        if (cyc == CYC_W'(WINDOW_CYC - 1)) begin
                            cyc     <= '0;
                            ro_en_a <= '0;
                            ro_en_b <= '0;
                            state   <= STOP;
                        end else begin
                            cyc <= cyc + CYC_W'(1);
                        end
                    end else if (fin_a_s || fin_b_s) begin
                        // A flag seen in the same clock as the other's is a tie.
                        resp    <= fin_a_s && !fin_b_s;
                        tie     <= fin_a_s && fin_b_s;
                        cyc     <= '0;
                        ro_en_a <= '0;
                        ro_en_b <= '0;
                        state   <= STOP;
                    end else if (cyc == CYC_W'(TIMEOUT_CYC - 1)) begin
                        timeout <= 1'b1;
                        cyc     <= '0;
                        ro_en_a <= '0;
                        ro_en_b <= '0;
                        state   <= STOP;
                    end else begin
                        cyc <= cyc + CYC_W'(1);
                    end
                end
                STOP: begin
                    if (cyc == CYC_W'(DRAIN_CYC - 1)) begin
                        // ROs have been off long enough that the counts are static.
                        if (mode_q == WINDOW) begin
                            count_a <= cnt_a;
                            count_b <= cnt_b;
                            resp    <= cnt_a > cnt_b;
                            tie     <= cnt_a == cnt_b;
                        end
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        cyc <= cyc + CYC_W'(1);
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_puf_race_unit.sv
// Bench for puf_race_unit: behavioural RO banks with per-instance periods and an
// edge-timing reference model of the race/window outcome and latency.
module tb_puf_race_unit;

    localparam int unsigned N_RO   = 16;
    localparam int unsigned CNT_W  = 10;
    localparam int unsigned TERM   = 64;
    localparam int unsigned SETTLE = 16;
    localparam int unsigned WINDOW = 256;
    localparam int unsigned DRAIN  = 8;
    localparam int unsigned TMO    = 256;
    localparam int unsigned SYNC   = 2;

    localparam longint TCLK       = 10000;
    localparam longint L1         = TCLK * (1 + SETTLE);
    localparam longint L2         = TCLK * (1 + SETTLE + WINDOW);
    localparam int     LIMIT_EDGE = 1 + SETTLE + TMO;
    localparam int     NEVER      = LIMIT_EDGE + 1000;
    localparam int     LAT_BOUND  = 400;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             mode = 1'b0;
    logic             resp_ready = 1'b1;
    logic [7:0]       challenge = 8'h00;
    logic             busy, resp_valid, resp, tie, timeout;
    logic [CNT_W-1:0] count_a, count_b;
    logic [N_RO-1:0]  ro_en_a, ro_en_b;
    wire  [N_RO-1:0]  ro_a, ro_b;

    int unsigned per_a [N_RO];
    int unsigned per_b [N_RO];
    int          n_checks = 0;
    int          n_pass = 0;

    puf_race_unit #(
        .N_RO(N_RO), .CNT_W(CNT_W), .TERM_COUNT(TERM), .SETTLE_CYC(SETTLE),
        .WINDOW_CYC(WINDOW), .DRAIN_CYC(DRAIN), .TIMEOUT_CYC(TMO), .SYNC_STG(SYNC)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .challenge(challenge),
        .mode(mode), .busy(busy), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp(resp), .tie(tie), .timeout(timeout), .count_a(count_a),
        .count_b(count_b), .ro_a(ro_a), .ro_b(ro_b), .ro_en_a(ro_en_a),
        .ro_en_b(ro_en_b)
    );

    always #5000 clock = ~clock;

    // Each RO starts low and toggles every half period while enabled; period 0 = stuck.
    for (genvar i = 0; i < N_RO; i++) begin : g_ro
        logic ra = 1'b0;
        logic rb = 1'b0;
        assign ro_a[i] = ra;
        assign ro_b[i] = rb;
        always begin
            if (ro_en_a[i] && per_a[i] != 0) begin
                #(per_a[i] / 2);
                ra = ro_en_a[i] ? ~ra : 1'b0;
            end else begin
                ra = 1'b0;
                @(ro_en_a[i]);
            end
        end
        always begin
            if (ro_en_b[i] && per_b[i] != 0) begin
                #(per_b[i] / 2);
                rb = ro_en_b[i] ? ~rb : 1'b0;
            end else begin
                rb = 1'b0;
                @(ro_en_b[i]);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // RO rising edges strictly before time x (ps after the RO enable edge).
    function automatic longint n_before(input longint x, input longint p);
        longint h;
        h = p / 2;
        if (p == 0 || x <= h) return 0;
        return (x - h + p - 1) / p;
    endfunction

    function automatic longint win_count(input int unsigned p);
        longint c;
        longint cmax;
        cmax = (longint'(1) << CNT_W) - 1;
        c = n_before(L2, longint'(p)) - n_before(L1, longint'(p));
        return (c > cmax) ? cmax : c;
    endfunction

    // Clock edge (counted from accept) at which the controller acts on this RO's flag.
    function automatic int race_stop(input int unsigned p);
        longint t;
        if (p == 0) return NEVER;
        t = longint'(p / 2) + longint'(p) * (n_before(L1, longint'(p)) + TERM - 1);
        return int'(t / TCLK) + 1 + int'(SYNC);
    endfunction

    function automatic int unsigned pick_period();
        case ($urandom_range(0, 6))
            0:       return 0;
            1:       return 2000;
            2:       return 2200;
            3:       return 2500;
            4:       return 2900;
            5:       return 3000;
            default: return 3500;
        endcase
    endfunction

    task automatic set_pair(input logic [7:0] ch, input int unsigned pa, input int unsigned pb);
        for (int i = 0; i < int'(N_RO); i++) begin
            per_a[i] = pick_period();
            per_b[i] = pick_period();
        end
        per_a[ch[3:0]] = pa;
        per_b[ch[7:4]] = pb;
    endtask

    task automatic run_one(input string name, input logic [7:0] ch, input logic m,
                           input int hold, input bit poke);
        int unsigned pa, pb;
        longint      ca, cb;
        int          na, nb, lat, e_lat;
        logic        e_resp, e_tie, e_tmo;
        logic [N_RO-1:0] oh_a, oh_b;
        pa = per_a[ch[3:0]];
        pb = per_b[ch[7:4]];
        oh_a = N_RO'(1) << ch[3:0];
        oh_b = N_RO'(1) << ch[7:4];
        ca = 0; cb = 0; e_tmo = 1'b0; e_tie = 1'b0; e_resp = 1'b0;
        if (m) begin
            ca = win_count(pa);
            cb = win_count(pb);
            e_resp = ca > cb;
            e_tie = ca == cb;
            e_lat = 1 + SETTLE + WINDOW + DRAIN;
        end else begin
            na = race_stop(pa);
            nb = race_stop(pb);
            if (na > LIMIT_EDGE && nb > LIMIT_EDGE) begin
                e_tmo = 1'b1;
                e_lat = LIMIT_EDGE + DRAIN;
            end else begin
                e_tie = na == nb;
                e_resp = na < nb;
                e_lat = ((na < nb) ? na : nb) + DRAIN;
            end
        end

        resp_ready = (hold == 0);
        @(negedge clock);
        challenge = ch; mode = m; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check({name, "/busy_accept"}, 32'(busy), 32'd1);
        check({name, "/en_a"}, 32'(ro_en_a), 32'(oh_a));
        check({name, "/en_b"}, 32'(ro_en_b), 32'(oh_b));
        if (poke) begin
            challenge = 8'($urandom);
            mode = ~m;
        end
        lat = 0;
        while (resp_valid !== 1'b1 && lat < LAT_BOUND) begin
            @(posedge clock); #1;
            lat++;
            if (poke) start = (lat % 5 == 2);
        end
        start = 1'b0;
        check({name, "/latency"}, 32'(lat), 32'(e_lat));
        check({name, "/resp"}, 32'(resp), 32'(e_resp));
        check({name, "/tie"}, 32'(tie), 32'(e_tie));
        check({name, "/timeout"}, 32'(timeout), 32'(e_tmo));
        check({name, "/count_a"}, 32'(count_a), 32'(ca));
        check({name, "/count_b"}, 32'(count_b), 32'(cb));
        check({name, "/ro_off"}, 32'({ro_en_a, ro_en_b}), 32'd0);
        for (int j = 0; j < hold; j++) begin
            @(posedge clock); #1;
            check({name, "/hold_valid"}, 32'(resp_valid), 32'd1);
            check({name, "/hold_out"}, 32'({resp, tie, timeout, count_a}),
                  32'({e_resp, e_tie, e_tmo, CNT_W'(ca)}));
        end
        resp_ready = 1'b1;
        @(posedge clock); #1;
        check({name, "/idle_valid"}, 32'(resp_valid), 32'd0);
        check({name, "/idle_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic abort_run(input logic [7:0] ch);
        @(negedge clock);
        challenge = ch; mode = 1'b1; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (60) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("abort/busy", 32'(busy), 32'd0);
        check("abort/valid", 32'(resp_valid), 32'd0);
        check("abort/flags", 32'({resp, tie, timeout}), 32'd0);
        check("abort/counts", 32'({count_a, count_b}), 32'd0);
        check("abort/ro_en", 32'({ro_en_a, ro_en_b}), 32'd0);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #(400_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < int'(N_RO); i++) begin
            per_a[i] = 3000;
            per_b[i] = 3000;
        end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("reset/busy", 32'(busy), 32'd0);
        check("reset/valid", 32'(resp_valid), 32'd0);
        check("reset/flags", 32'({resp, tie, timeout}), 32'd0);
        check("reset/counts", 32'({count_a, count_b}), 32'd0);
        check("reset/ro_en", 32'({ro_en_a, ro_en_b}), 32'd0);
        reset = 1'b0;

        set_pair(8'h35, 2000, 2200); run_one("race_a_fast", 8'h35, 1'b0, 10, 1'b1);
        set_pair(8'h35, 2200, 2000); run_one("race_b_fast", 8'h35, 1'b0, 0, 1'b0);
        set_pair(8'h35, 2500, 2500); run_one("race_tie", 8'h35, 1'b0, 0, 1'b0);
        set_pair(8'h35, 3000, 3000); run_one("win_tie", 8'h35, 1'b1, 0, 1'b0);
        set_pair(8'h35, 2900, 3000); run_one("win_a_fast", 8'h35, 1'b1, 3, 1'b1);
        set_pair(8'hc1, 2000, 3000); run_one("win_sat", 8'hc1, 1'b1, 0, 1'b0);
        set_pair(8'h35, 0, 0);       run_one("race_timeout", 8'h35, 1'b0, 0, 1'b0);
        set_pair(8'h35, 0, 3500);    run_one("race_a_stuck", 8'h35, 1'b0, 0, 1'b0);

        abort_run(8'h7e);
        set_pair(8'h7e, 2500, 3500); run_one("after_abort", 8'h7e, 1'b0, 0, 1'b0);

        for (int k = 0; k < 12; k++) begin
            logic [7:0] ch;
            ch = 8'($urandom);
            set_pair(ch, pick_period(), pick_period());
            run_one($sformatf("rand%0d", k), ch, 1'($urandom), int'($urandom_range(0, 3)),
                    1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
